// File: rtl/mdio_phy_slv_pkg.sv
// Shared MDIO clause-22 definitions: FSM states, frame codes, field lengths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mdio_phy_slv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ST,
      S_OP,
      S_PHYAD,
      S_REGAD,
      S_TA,
      S_DATA
   } state_t;

   localparam logic [1:0] ST_CODE = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [1:0] OP_WR   = 2'b01;

   localparam logic [4:0] ST_LEN   = 5'd2;
   localparam logic [4:0] OP_LEN   = 5'd2;
   localparam logic [4:0] ADDR_LEN = 5'd5;
   localparam logic [4:0] TA_LEN   = 5'd2;
   localparam logic [4:0] DATA_LEN = 5'd16;

   // Bit-counter value at which the current field's last bit is sampled.
   function automatic logic [4:0] field_last(input state_t s);
      case (s)
         S_ST:    field_last = ST_LEN - 5'd2;   // first ST bit is consumed in IDLE
         S_OP:    field_last = OP_LEN - 5'd1;
         S_PHYAD: field_last = ADDR_LEN - 5'd1;
         S_REGAD: field_last = ADDR_LEN - 5'd1;
         S_TA:    field_last = TA_LEN - 5'd1;
         S_DATA:  field_last = DATA_LEN - 5'd1;
         default: field_last = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/mdio_phy_regfile.sv
// PHY register file, 32x16: regs 1..3 fixed read-only, reg0 bit15 soft reset.
// Latency: write lands on the we edge; read is combinational from raddr.
// Backpressure: none, a write is always accepted.
// Ports: CLK/RSTn clock and async reset; we/waddr/wdata write port; raddr/rdata read port.
module mdio_phy_regfile
   import mdio_phy_slv_pkg::*;
#(
   parameter logic [15:0] PHY_STATUS = 16'h796D,
   parameter logic [15:0] PHY_ID1    = 16'h0022,
   parameter logic [15:0] PHY_ID2    = 16'h1622
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [15:0] wdata,
   input  logic [4:0]  raddr,
   output logic [15:0] rdata
);

   logic [15:0] mem_q [32];
   logic [15:0] mem_d [32];
   logic        wr_ro;

   // Regs 1..3 are constants; writes to them are dropped here.
   assign wr_ro = (waddr == 5'd1) || (waddr == 5'd2) || (waddr == 5'd3);

   always_comb begin
      for (int i = 0; i < 32; i++) mem_d[i] = mem_q[i];
      if (we && !wr_ro) begin
         if (waddr == 5'd0 && wdata[15]) begin
            // Soft reset clears every writable reg, then reg0 keeps the written
            // value with its self-clearing bit already dropped.
            for (int i = 0; i < 32; i++) mem_d[i] = 16'h0000;
            mem_d[0] = {1'b0, wdata[14:0]};
         end else begin
            mem_d[waddr] = wdata;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < 32; i++) mem_q[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < 32; i++) mem_q[i] <= mem_d[i];
      end
   end

   always_comb begin
      case (raddr)
         5'd1:    rdata = PHY_STATUS;
         5'd2:    rdata = PHY_ID1;
         5'd3:    rdata = PHY_ID2;
         default: rdata = mem_q[raddr];
      endcase
   end

endmodule

// File: rtl/mdio_phy_slv.sv
// Clause-22 MDIO PHY responder: decodes MAC frames, owns the PHY regfile, drives read data on MDI.
// Latency: MDI updates 1 CLK after an MDC rise is seen; wr_pulse fires 1 CLK after the last data rise.
// Backpressure: none; the MAC paces everything through MDC, which is sampled in the CLK domain.
// Ports: CLK/RSTn; MDC/MDO/MDOEN from the MAC; MDI back to the MAC (1 when released);
//        wr_pulse/wr_regad/wr_data report committed writes; frame_err is sticky until reset.
module mdio_phy_slv
   import mdio_phy_slv_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR     = 5'd1,
   parameter int          PREAMBLE_LEN = 32,
   parameter logic [15:0] PHY_STATUS   = 16'h796D,
   parameter logic [15:0] PHY_ID1      = 16'h0022,
   parameter logic [15:0] PHY_ID2      = 16'h1622
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        MDC,
   input  logic        MDO,
   input  logic        MDOEN,
   output logic        MDI,
   output logic        wr_pulse,
   output logic [4:0]  wr_regad,
   output logic [15:0] wr_data,
   output logic        frame_err
);

   localparam int            PW      = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

   state_t        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [14:0]   sr_q, sr_d;
   logic          is_rd_q, is_rd_d;
   logic          match_q, match_d;
   logic [4:0]    regad_q, regad_d;
   logic          drv_q, drv_d;
   logic          mdi_q, mdi_d;
   logic          mdc_q;
   logic          wr_pulse_q, wr_pulse_d;
   logic [4:0]    wr_regad_q, wr_regad_d;
   logic [15:0]   wr_data_q, wr_data_d;
   logic          frame_err_q, frame_err_d;

   logic          rise, line, last;
   logic          rf_we;
   logic [15:0]   rf_wdata, rf_rdata;
   logic [3:0]    bit_idx;

   assign rise    = MDC & ~mdc_q;
   // Resolved bus value: MAC wins when enabled, otherwise our driver or the pull-up.
   assign line    = MDOEN ? MDO : (drv_q ? mdi_q : 1'b1);
   assign last    = (cnt_q == field_last(state_q));
   // During DATA, the rise at count k loads the bit the MAC samples next (k+1 from MSB).
   assign bit_idx = 4'd14 - cnt_q[3:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pre_cnt_d   = pre_cnt_q;
      sr_d        = sr_q;
      is_rd_d     = is_rd_q;
      match_d     = match_q;
      regad_d     = regad_q;
      drv_d       = drv_q;
      mdi_d       = mdi_q;
      wr_pulse_d  = 1'b0;
      wr_regad_d  = wr_regad_q;
      wr_data_d   = wr_data_q;
      frame_err_d = frame_err_q;
      rf_we       = 1'b0;
      rf_wdata    = {sr_q, line};

      if (rise) begin
         if (MDOEN && drv_q) frame_err_d = 1'b1;   // bus contention; we keep driving
         sr_d  = {sr_q[13:0], line};
         cnt_d = last ? 5'd0 : cnt_q + 5'd1;

         case (state_q)
            S_IDLE: begin
               cnt_d = 5'd0;
               if (line) begin
                  if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + PW'(1);
               end else if (pre_cnt_q == PRE_MAX && line == ST_CODE[1]) begin
                  state_d   = S_ST;
                  pre_cnt_d = '0;
               end else begin
                  pre_cnt_d = '0;
               end
            end
            S_ST: begin
               if (line == ST_CODE[0]) begin
                  state_d = S_OP;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
            S_OP: begin
               if (last) begin
                  if ({sr_q[0], line} == OP_RD) begin
                     is_rd_d = 1'b1;
                     state_d = S_PHYAD;
                  end else if ({sr_q[0], line} == OP_WR) begin
                     is_rd_d = 1'b0;
                     state_d = S_PHYAD;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_IDLE;
                  end
               end
            end
            S_PHYAD: begin
               if (last) begin
                  match_d = ({sr_q[3:0], line} == PHY_ADDR);
                  state_d = S_REGAD;
               end
            end
            S_REGAD: begin
               if (last) begin
                  regad_d = {sr_q[3:0], line};
                  state_d = S_TA;
                  if (is_rd_q && match_q) begin
                     drv_d = 1'b1;
                     mdi_d = 1'b1;   // first TA bit: line still reads high
                  end
               end
            end
            S_TA: begin
               if (drv_q) mdi_d = last ? rf_rdata[15] : 1'b0;
               if (last) state_d = S_DATA;
            end
            S_DATA: begin
               if (last) begin
                  state_d = S_IDLE;
                  drv_d   = 1'b0;
                  mdi_d   = 1'b1;
                  if (!is_rd_q && match_q) begin
                     rf_we      = 1'b1;
                     wr_pulse_d = 1'b1;
                     wr_regad_d = regad_q;
                     wr_data_d  = {sr_q, line};
                  end
               end else if (drv_q) begin
                  mdi_d = rf_rdata[bit_idx];
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         pre_cnt_q   <= '0;
         sr_q        <= '0;
         is_rd_q     <= 1'b0;
         match_q     <= 1'b0;
         regad_q     <= 5'd0;
         drv_q       <= 1'b0;
         mdi_q       <= 1'b1;
         mdc_q       <= 1'b0;
         wr_pulse_q  <= 1'b0;
         wr_regad_q  <= 5'd0;
         wr_data_q   <= 16'h0000;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pre_cnt_q   <= pre_cnt_d;
         sr_q        <= sr_d;
         is_rd_q     <= is_rd_d;
         match_q     <= match_d;
         regad_q     <= regad_d;
         drv_q       <= drv_d;
         mdi_q       <= mdi_d;
         mdc_q       <= MDC;
         wr_pulse_q  <= wr_pulse_d;
         wr_regad_q  <= wr_regad_d;
         wr_data_q   <= wr_data_d;
         frame_err_q <= frame_err_d;
      end
   end

   mdio_phy_regfile #(
      .PHY_STATUS (PHY_STATUS),
      .PHY_ID1    (PHY_ID1),
      .PHY_ID2    (PHY_ID2)
   ) u_regfile (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .we    (rf_we),
      .waddr (regad_q),
      .wdata (rf_wdata),
      .raddr (regad_q),
      .rdata (rf_rdata)
   );

   assign MDI       = mdi_q;
   assign wr_pulse  = wr_pulse_q;
   assign wr_regad  = wr_regad_q;
   assign wr_data   = wr_data_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_slv.sv
// Self-checking bench for mdio_phy_slv: directed clause-22 frames plus random write/read traffic.
// Latency: MDC = CLK/8, MDI sampled just before each MDC rise, as a MAC would.
// Backpressure: n/a.
module tb_mdio_phy_slv;

   localparam logic [4:0] PHY = 5'd1;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        MDC;
   logic        MDO;
   logic        MDOEN;
   logic        MDI;
   logic        wr_pulse;
   logic [4:0]  wr_regad;
   logic [15:0] wr_data;
   logic        frame_err;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int mdi_low = 0;

   logic [15:0] model [32];

   always #5 CLK = ~CLK;

   mdio_phy_slv #(
      .PHY_ADDR     (5'd1),
      .PREAMBLE_LEN (32),
      .PHY_STATUS   (16'h796D),
      .PHY_ID1      (16'h0022),
      .PHY_ID2      (16'h1622)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .MDC       (MDC),
      .MDO       (MDO),
      .MDOEN     (MDOEN),
      .MDI       (MDI),
      .wr_pulse  (wr_pulse),
      .wr_regad  (wr_regad),
      .wr_data   (wr_data),
      .frame_err (frame_err)
   );

   always @(negedge CLK) begin
      if (wr_pulse === 1'b1) wr_cnt++;
      if (MDI === 1'b0) mdi_low++;
   end

   // ---------------- reference model: PHY register semantics ----------------
   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
   endfunction

   function automatic void model_wr(input logic [4:0] a, input logic [15:0] d);
      if (a >= 5'd1 && a <= 5'd3) return;
      if (a == 5'd0 && d[15]) begin
         model_reset();
         model[0] = d & 16'h7FFF;
      end else begin
         model[a] = d;
      end
   endfunction

   function automatic logic [15:0] model_rd(input logic [4:0] a);
      if (a == 5'd1) return 16'h796D;
      if (a == 5'd2) return 16'h0022;
      if (a == 5'd3) return 16'h1622;
      return model[a];
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One MDC period: drive MDO/MDOEN in the low half, sample MDI just before the rise.
   task automatic mdc_cycle(input logic en, input logic d, output logic mdi_s);
      @(negedge CLK);
      MDOEN = en;
      MDO   = d;
      MDC   = 1'b0;
      repeat (3) @(negedge CLK);
      mdi_s = MDI;
      @(negedge CLK);
      MDC = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   // Full frame; for reads the MAC releases the line for TA+DATA and got collects MDI.
   task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic rd, output logic [17:0] got);
      logic        s;
      logic [13:0] hdr;
      logic [17:0] tail;
      hdr  = {st, op, pa, ra};
      tail = {2'b10, wd};
      got  = '0;
      for (int i = 0; i < pre; i++) mdc_cycle(1'b1, 1'b1, s);
      for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, hdr[i], s);
      for (int i = 17; i >= 0; i--) begin
         if (rd) begin
            mdc_cycle(1'b0, 1'b0, s);
            got[i] = s;
         end else begin
            mdc_cycle(1'b1, tail[i], s);
         end
      end
   endtask

   task automatic do_write(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input string tag);
      int          n0;
      logic        hit;
      logic [17:0] got;
      n0  = wr_cnt;
      send_frame(pre, 2'b01, 2'b01, pa, ra, wd, 1'b0, got);
      hit = (pa == PHY) && (pre >= 32);
      chk({tag, "_pulses"}, wr_cnt - n0, hit ? 32'd1 : 32'd0);
      if (hit) begin
         chk({tag, "_regad"}, wr_regad, ra);
         chk({tag, "_data"}, wr_data, wd);
         model_wr(ra, wd);
      end
   endtask

   task automatic do_read(input logic [4:0] pa, input logic [4:0] ra, input string tag);
      logic [17:0] got;
      logic [17:0] exp;
      send_frame(32, 2'b01, 2'b10, pa, ra, 16'h0000, 1'b1, got);
      exp = (pa == PHY) ? {2'b10, model_rd(ra)} : 18'h3FFFF;
      chk(tag, got, exp);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic        s;
      logic [17:0] got;
      logic [13:0] hdr;
      int          n0;
      logic [4:0]  pa, ra, ra2;
      logic [15:0] wd;

      RSTn  = 1'b0;
      MDC   = 1'b0;
      MDO   = 1'b0;
      MDOEN = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK);
      chk("rst_mdi", MDI, 1'b1);
      chk("rst_wr_pulse", wr_pulse, 1'b0);
      chk("rst_wr_regad", wr_regad, 5'd0);
      chk("rst_wr_data", wr_data, 16'h0000);
      chk("rst_frame_err", frame_err, 1'b0);
      RSTn = 1'b1;
      repeat (3) @(negedge CLK);

      // 1: write/read reg4
      do_write(32, PHY, 5'd4, 16'hA5A5, "t1_wr");
      do_read(PHY, 5'd4, "t1_rd");

      // 2: ID registers, write to read-only reg is reported but not stored
      do_read(PHY, 5'd2, "t2_id1");
      do_read(PHY, 5'd3, "t2_id2");
      do_write(32, PHY, 5'd2, 16'hFFFF, "t2_wr_ro");
      do_read(PHY, 5'd2, "t2_id1_again");
      chk("t2_no_err", frame_err, 1'b0);

      // 3: other PHYAD is ignored and MDI never leaves 1
      n0 = mdi_low;
      do_write(32, 5'd5, 5'd4, 16'h5A5A, "t3_wr");
      do_read(5'd5, 5'd4, "t3_rd");
      chk("t3_mdi_high", mdi_low - n0, 32'd0);
      do_read(PHY, 5'd4, "t3_reg4_kept");

      // 4: short preamble ignored; bad ST flags frame_err and FSM recovers
      do_write(31, PHY, 5'd4, 16'h0F0F, "t4_short_pre");
      chk("t4_no_err", frame_err, 1'b0);
      n0 = wr_cnt;
      send_frame(32, 2'b00, 2'b01, PHY, 5'd4, 16'h3C3C, 1'b0, got);
      chk("t4_st_pulses", wr_cnt - n0, 32'd0);
      chk("t4_st_err", frame_err, 1'b1);
      do_write(32, PHY, 5'd6, 16'hBEEF, "t4_recover");
      do_read(PHY, 5'd6, "t4_recover_rd");

      // 5: soft reset through reg0 bit15
      do_write(32, PHY, 5'd4, 16'h1234, "t5_wr4");
      do_write(32, PHY, 5'd0, 16'h9140, "t5_wr0");
      do_read(PHY, 5'd0, "t5_rd0");
      do_read(PHY, 5'd4, "t5_rd4");
      do_read(PHY, 5'd6, "t5_rd6");

      // random traffic against the model
      for (int it = 0; it < 14; it++) begin
         pa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : PHY;
         ra  = 5'($urandom_range(0, 31));
         wd  = 16'($urandom);
         ra2 = ($urandom_range(0, 1) == 0) ? ra : 5'($urandom_range(0, 31));
         do_write(32, pa, ra, wd, $sformatf("rnd%0d_wr", it));
         do_read(($urandom_range(0, 3) == 0) ? 5'd9 : PHY, ra2, $sformatf("rnd%0d_rd", it));
      end

      // 6: async reset in the middle of a read's data phase
      do_write(32, PHY, 5'd4, 16'h0000, "t6_wr4");
      hdr = {2'b01, 2'b10, PHY, 5'd4};
      for (int i = 0; i < 32; i++) mdc_cycle(1'b1, 1'b1, s);
      for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, hdr[i], s);
      for (int i = 0; i < 6; i++) mdc_cycle(1'b0, 1'b0, s);
      chk("t6_mid_data", s, 1'b0);
      @(negedge CLK);
      #2;
      RSTn = 1'b0;
      #1;
      chk("t6_async_mdi", MDI, 1'b1);
      chk("t6_async_err", frame_err, 1'b0);
      model_reset();
      MDC   = 1'b0;
      MDOEN = 1'b0;
      repeat (3) @(negedge CLK);
      RSTn = 1'b1;
      repeat (3) @(negedge CLK);
      do_read(PHY, 5'd1, "t6_status");
      do_read(PHY, 5'd0, "t6_reg0");
      do_write(32, PHY, 5'd7, 16'hC001, "t6_wr7");
      do_read(PHY, 5'd7, "t6_rd7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
